// File: rtl/irq_vector_ctrl_if.sv
// Bus bundle between the interrupt controller and the CPU's PC next-address mux.
// The slave side is the controller; the master side is the CPU / request sources.
// Widths follow N_IRQ (request lines) and PC_W (program counter).
interface irq_vector_ctrl_if #(
   parameter int N_IRQ = 4,
   parameter int PC_W  = 10
);
   localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

   // Request side
   logic [N_IRQ-1:0] irq_in;
   logic             mask_we;
   logic [N_IRQ-1:0] mask_wd;

   // CPU side
   logic [PC_W-1:0]  pc_next;
   logic             reti;
   logic             take;
   logic [PC_W-1:0]  vec_out;
   logic [PC_W-1:0]  ret_addr;

   // Status
   logic             active;
   logic [ID_W-1:0]  active_id;
   logic [N_IRQ-1:0] pending_q;
   logic [N_IRQ-1:0] mask_q;

   modport master (
      output irq_in, mask_we, mask_wd, pc_next, reti,
      input  take, vec_out, ret_addr, active, active_id, pending_q, mask_q
   );

   modport slave (
      input  irq_in, mask_we, mask_wd, pc_next, reti,
      output take, vec_out, ret_addr, active, active_id, pending_q, mask_q
   );
endinterface

// File: rtl/irq_vector_ctrl.sv
// Priority interrupt controller in front of the PC register; optional nesting via macro IRQ_NEST_EN.
// Latency: irq_in rise -> pending_q at 3rd edge, pending&unmasked -> take 1 edge later, take lasts 1 cycle.
// No backpressure: requests stay latched in pending_q until serviced; nothing is ever dropped.
module irq_vector_ctrl #(
   parameter int              N_IRQ      = 4,
   parameter int              PC_W       = 10,
   parameter logic [PC_W-1:0] VEC_BASE   = 10'h3C0,
   parameter int              VEC_STRIDE = 4,
   parameter int              NEST_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   irq_vector_ctrl_if.slave bus
);

   localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

`ifdef IRQ_NEST_EN
   localparam bit NEST_EN = 1'b1;
`else
   localparam bit NEST_EN = 1'b0;
`endif

   // Without nesting the return "stack" collapses to the single return register.
   localparam int STK_D = (NEST_EN && NEST_DEPTH > 1) ? NEST_DEPTH : 1;
   localparam int SP_W  = $clog2(STK_D + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      TAKE    = 2'd1,
      SERVICE = 2'd2
   } state_t;

   // Synchroniser and request latch
   logic [N_IRQ-1:0] sync1_q;
   logic [N_IRQ-1:0] sync2_q;
   logic [N_IRQ-1:0] dly_q;
   logic [N_IRQ-1:0] rise;
   logic [N_IRQ-1:0] pend_q;
   logic [N_IRQ-1:0] pend_d;
   logic [N_IRQ-1:0] msk_q;
   logic [N_IRQ-1:0] msk_d;
   logic [N_IRQ-1:0] clr;

   // Priority selection
   logic [N_IRQ-1:0] cand;
   logic [N_IRQ-1:0] sel;
   logic             sel_vld;
   logic [ID_W-1:0]  sel_id;
   logic [PC_W-1:0]  vec_d;
   logic             preempt;

   // Control state and registered outputs
   state_t           state_q;
   logic             take_q;
   logic [PC_W-1:0]  vec_q;
   logic [ID_W-1:0]  take_id_q;
   logic             active_q;

   // Return stack: entry 0 is the top, entries at or beyond sp_q are kept zero
   logic [PC_W-1:0]  ret_stk_q [STK_D];
   logic [ID_W-1:0]  id_stk_q  [STK_D];
   logic [SP_W-1:0]  sp_q;

   // Rising-edge detect on the synchronised lines
   always_comb begin
      rise = sync2_q & ~dly_q;
   end

   // Next pending/mask: new edges win over the clear of the bit being taken
   always_comb begin
      clr = '0;
      if (state_q == TAKE) begin
         clr[take_id_q] = 1'b1;
      end
      pend_d = (pend_q & ~clr) | rise;
      msk_d  = bus.mask_we ? bus.mask_wd : msk_q;
   end

   // Synchroniser, edge-detect delay, pending latch and mask register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         dly_q   <= '0;
         pend_q  <= '0;
         msk_q   <= '0;
      end else begin
         sync1_q <= bus.irq_in;
         sync2_q <= sync1_q;
         dly_q   <= sync2_q;
         pend_q  <= pend_d;
         msk_q   <= msk_d;
      end
   end

   // Lowest set bit of the enabled requests wins; encode its index and vector
   always_comb begin
      cand    = pend_q & msk_q;
      sel     = cand & (~cand + N_IRQ'(1));
      sel_vld = |cand;
      sel_id  = '0;
      for (int i = 0; i < N_IRQ; i++) begin
         if (sel[i]) begin
            sel_id = sel_id | ID_W'(i);
         end
      end
      vec_d = VEC_BASE + PC_W'(sel_id) * PC_W'(VEC_STRIDE);
   end

`ifdef IRQ_NEST_EN
   logic stk_full;

   // Preempt only a strictly lower-priority handler, and only while the stack has room
   always_comb begin
      stk_full = (sp_q == SP_W'(STK_D));
      preempt  = sel_vld && (sel_id < id_stk_q[0]) && !stk_full;
   end
`else
   // Single-level service: requests wait in pending_q until the handler returns
   always_comb begin
      preempt = 1'b0;
   end
`endif

   // Control FSM: take sequencing, return-stack push/pop and registered take/vector outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         take_q    <= 1'b0;
         vec_q     <= '0;
         take_id_q <= '0;
         active_q  <= 1'b0;
         sp_q      <= '0;
         for (int i = 0; i < STK_D; i++) begin
            ret_stk_q[i] <= '0;
            id_stk_q[i]  <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               // reti has nothing to return from here and is ignored
               if (sel_vld) begin
                  state_q   <= TAKE;
                  take_q    <= 1'b1;
                  vec_q     <= vec_d;
                  take_id_q <= sel_id;
               end
            end

            TAKE: begin
               // Closing edge of the take: PC loads vec_out, so pc_next is the return point.
               // reti and mask writes here cannot cancel the take.
               take_q       <= 1'b0;
               active_q     <= 1'b1;
               sp_q         <= sp_q + SP_W'(1);
               ret_stk_q[0] <= bus.pc_next;
               id_stk_q[0]  <= take_id_q;
               for (int i = 1; i < STK_D; i++) begin
                  ret_stk_q[i] <= ret_stk_q[i-1];
                  id_stk_q[i]  <= id_stk_q[i-1];
               end
               state_q <= SERVICE;
            end

            SERVICE: begin
               if (bus.reti) begin
                  // Return has priority over a coincident preemption; it is re-evaluated next cycle
                  for (int i = 0; i < STK_D - 1; i++) begin
                     ret_stk_q[i] <= ret_stk_q[i+1];
                     id_stk_q[i]  <= id_stk_q[i+1];
                  end
                  ret_stk_q[STK_D-1] <= '0;
                  id_stk_q[STK_D-1]  <= '0;
                  sp_q               <= sp_q - SP_W'(1);
                  if (sp_q == SP_W'(1)) begin
                     state_q  <= IDLE;
                     active_q <= 1'b0;
                  end
               end else if (preempt) begin
                  state_q   <= TAKE;
                  take_q    <= 1'b1;
                  vec_q     <= vec_d;
                  take_id_q <= sel_id;
               end
            end

            default: begin
               state_q <= IDLE;
               take_q  <= 1'b0;
            end
         endcase
      end
   end

   // Outputs: take/vector/active are registered, return address and id come straight off the stack top
   assign bus.take      = take_q;
   assign bus.vec_out   = vec_q;
   assign bus.ret_addr  = ret_stk_q[0];
   assign bus.active    = active_q;
   assign bus.active_id = id_stk_q[0];
   assign bus.pending_q = pend_q;
   assign bus.mask_q    = msk_q;

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// Self-checking bench for irq_vector_ctrl: directed scenarios plus randomized traffic.
// A per-edge reference model pushes expected vectors into a scoreboard; a monitor pops on take.
// Nesting expectations follow whether IRQ_NEST_EN is defined for the build.
module tb_irq_vector_ctrl;

   localparam int              N_IRQ      = 4;
   localparam int              PC_W       = 10;
   localparam logic [PC_W-1:0] VEC_BASE   = 10'h3C0;
   localparam int              VEC_STRIDE = 4;
   localparam int              NEST_DEPTH = 4;

`ifdef IRQ_NEST_EN
   localparam bit NEST = 1'b1;
`else
   localparam bit NEST = 1'b0;
`endif

   typedef struct {
      logic [PC_W-1:0] ret;
      int              id;
   } ctx_t;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   irq_vector_ctrl_if #(.N_IRQ(N_IRQ), .PC_W(PC_W)) b();

   irq_vector_ctrl #(
      .N_IRQ(N_IRQ), .PC_W(PC_W), .VEC_BASE(VEC_BASE),
      .VEC_STRIDE(VEC_STRIDE), .NEST_DEPTH(NEST_DEPTH)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(b)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [N_IRQ-1:0] m_pend, m_mask;
   logic [N_IRQ-1:0] h1, h2, h3;       // irq_in as sampled 1, 2, 3 edges ago
   bit               m_take;
   int               m_take_id;
   ctx_t             m_stk[$];         // front = handler currently running
   logic [PC_W-1:0]  sb_vec[$];        // scoreboard of expected vectors

   function automatic int lowest(input logic [N_IRQ-1:0] v);
      for (int i = 0; i < N_IRQ; i++) if (v[i]) return i;
      return -1;
   endfunction

   always @(posedge clk) begin : model
      logic [N_IRQ-1:0] rise, clr;
      int               id;
      bit               go;
      ctx_t             c;
      if (reset) begin
         m_pend = '0; m_mask = '0;
         h1 = '0; h2 = '0; h3 = '0;
         m_take = 1'b0; m_take_id = 0;
         m_stk.delete();
         sb_vec.delete();
      end else begin
         // A request becomes pending once its 0->1 step has crossed the two sync stages
         rise = h2 & ~h3;
         clr  = '0;
         go   = 1'b0;
         id   = lowest(m_pend & m_mask);
         if (m_take) begin
            c.ret = b.pc_next;
            c.id  = m_take_id;
            m_stk.push_front(c);
            clr[m_take_id] = 1'b1;
         end else if (m_stk.size() != 0 && b.reti) begin
            void'(m_stk.pop_front());
         end else if (id >= 0) begin
            if (m_stk.size() == 0) go = 1'b1;
            else if (NEST && id < m_stk[0].id && m_stk.size() < NEST_DEPTH) go = 1'b1;
         end
         m_pend = (m_pend & ~clr) | rise;
         if (b.mask_we) m_mask = b.mask_wd;
         h3 = h2; h2 = h1; h1 = b.irq_in;
         m_take = go;
         if (go) begin
            m_take_id = id;
            sb_vec.push_back(PC_W'(int'(VEC_BASE) + id * VEC_STRIDE));
         end
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      #1;
      if (!reset) begin
         chk("take", 32'(b.take), 32'(m_take));
         if (b.take) begin
            if (sb_vec.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL vec_out: take with vec 0x%0h but none expected at %0t", b.vec_out, $time);
            end else begin
               chk("vec_out", 32'(b.vec_out), 32'(sb_vec.pop_front()));
            end
         end
         chk("pending_q", 32'(b.pending_q), 32'(m_pend));
         chk("mask_q", 32'(b.mask_q), 32'(m_mask));
         chk("active", 32'(b.active), 32'(m_stk.size() != 0));
         if (m_stk.size() != 0) begin
            chk("ret_addr", 32'(b.ret_addr), 32'(m_stk[0].ret));
            chk("active_id", 32'(b.active_id), 32'(m_stk[0].id));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         b.reti    = 1'b0;
         b.mask_we = 1'b0;
         b.pc_next = PC_W'($urandom);
      end
   endtask

   task automatic set_mask(input logic [N_IRQ-1:0] m);
      b.mask_we = 1'b1;
      b.mask_wd = m;
      tick(1);
   endtask

   task automatic pulse(input logic [N_IRQ-1:0] bits);
      b.irq_in = b.irq_in | bits;
      tick(2);
      b.irq_in = b.irq_in & ~bits;
   endtask

   task automatic wait_take(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         tick(1);
         if (b.take) seen = 1'b1;
      end
      chk({name, " take seen"}, 32'(seen), 32'd1);
   endtask

   task automatic do_reti();
      b.reti = 1'b1;
      tick(1);
   endtask

   logic [PC_W-1:0] ret_a, ret_b;
   int              takes;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      b.irq_in = '0; b.mask_we = 1'b0; b.mask_wd = '0; b.pc_next = '0; b.reti = 1'b0;
      reset = 1'b1;
      tick(2);
      chk("rst take", 32'(b.take), 0);
      chk("rst active", 32'(b.active), 0);
      chk("rst vec_out", 32'(b.vec_out), 0);
      chk("rst ret_addr", 32'(b.ret_addr), 0);
      chk("rst pending", 32'(b.pending_q), 0);
      chk("rst mask", 32'(b.mask_q), 0);
      reset = 1'b0;
      tick(2);

      // Single request, exact latency
      set_mask(4'b1111);
      tick(2);
      b.irq_in[2] = 1'b1;
      tick(3);
      chk("single no take at E3", 32'(b.take), 0);
      tick(1);
      chk("single take at E4", 32'(b.take), 1);
      chk("single vec", 32'(b.vec_out), 32'h3C8);
      ret_a = b.pc_next;
      b.irq_in[2] = 1'b0;
      tick(1);
      chk("single take one cycle", 32'(b.take), 0);
      chk("single active", 32'(b.active), 1);
      chk("single ret_addr", 32'(b.ret_addr), 32'(ret_a));
      tick(3);
      b.reti = 1'b1;
      chk("single ret_addr in reti", 32'(b.ret_addr), 32'(ret_a));
      tick(1);
      chk("single active after reti", 32'(b.active), 0);
      tick(2);

      // Priority between simultaneous requests
      pulse(4'b1010);
      wait_take("prio first");
      chk("prio first vec", 32'(b.vec_out), 32'h3C4);
      tick(3);
      do_reti();
      wait_take("prio second");
      chk("prio second vec", 32'(b.vec_out), 32'h3CC);
      tick(2);
      do_reti();
      tick(3);

      // Masked request stays pending until enabled
      set_mask(4'b0001);
      pulse(4'b0100);
      tick(6);
      chk("masked no take", 32'(b.take), 0);
      chk("masked pending", 32'(b.pending_q[2]), 1);
      chk("masked inactive", 32'(b.active), 0);
      set_mask(4'b0100);
      chk("unmask edge+1 no take", 32'(b.take), 0);
      tick(1);
      chk("unmask edge+2 take", 32'(b.take), 1);
      chk("unmask vec", 32'(b.vec_out), 32'h3C8);
      tick(2);
      do_reti();
      tick(2);

      // Higher-priority request during service
      set_mask(4'b1111);
      pulse(4'b1000);
      wait_take("nest irq3");
      chk("nest irq3 vec", 32'(b.vec_out), 32'h3CC);
      ret_a = b.pc_next;
      tick(2);
      pulse(4'b0001);
      if (NEST) begin
         wait_take("nest irq0");
         chk("nest irq0 vec", 32'(b.vec_out), 32'h3C0);
         ret_b = b.pc_next;
         tick(2);
         chk("nest active_id", 32'(b.active_id), 0);
         b.reti = 1'b1;
         chk("nest first ret", 32'(b.ret_addr), 32'(ret_b));
         tick(1);
         chk("nest still active", 32'(b.active), 1);
         chk("nest back to 3", 32'(b.active_id), 3);
         tick(1);
         b.reti = 1'b1;
         chk("nest second ret", 32'(b.ret_addr), 32'(ret_a));
         tick(1);
         chk("nest inactive", 32'(b.active), 0);
      end else begin
         takes = 0;
         for (int i = 0; i < 10; i++) begin
            tick(1);
            if (b.take) takes++;
         end
         chk("nonest no preempt", 32'(takes), 0);
         chk("nonest irq0 pending", 32'(b.pending_q[0]), 1);
         b.reti = 1'b1;
         chk("nonest ret", 32'(b.ret_addr), 32'(ret_a));
         tick(1);
         chk("nonest inactive", 32'(b.active), 0);
         wait_take("nonest irq0 after reti");
         chk("nonest irq0 vec", 32'(b.vec_out), 32'h3C0);
         tick(2);
         do_reti();
      end
      tick(3);

      // Reset in the middle of a service
      pulse(4'b0010);
      wait_take("rst-mid take");
      tick(2);
      chk("rst-mid active before", 32'(b.active), 1);
      reset = 1'b1;
      #2;
      chk("rst-mid take", 32'(b.take), 0);
      chk("rst-mid active", 32'(b.active), 0);
      chk("rst-mid active_id", 32'(b.active_id), 0);
      chk("rst-mid ret_addr", 32'(b.ret_addr), 0);
      chk("rst-mid vec_out", 32'(b.vec_out), 0);
      chk("rst-mid pending", 32'(b.pending_q), 0);
      chk("rst-mid mask", 32'(b.mask_q), 0);
      tick(2);
      reset = 1'b0;
      tick(1);
      do_reti();
      chk("rst-mid reti ignored", 32'(b.active), 0);
      chk("rst-mid no take", 32'(b.take), 0);

      // Randomized traffic against the model
      set_mask(N_IRQ'($urandom));
      for (int c = 0; c < 2500; c++) begin
         tick(1);
         if (c == 1200) begin
            reset = 1'b1;
            tick(2);
            reset = 1'b0;
         end
         if ($urandom_range(0, 7) == 0) begin
            int k;
            k = $urandom_range(0, N_IRQ - 1);
            b.irq_in[k] = ~b.irq_in[k];
         end
         if ($urandom_range(0, 39) == 0) begin
            b.mask_we = 1'b1;
            b.mask_wd = N_IRQ'($urandom);
         end
         if ($urandom_range(0, 5) == 0) b.reti = 1'b1;
      end

      // Drain outstanding service
      b.irq_in = '0;
      set_mask('0);
      for (int i = 0; i < 60 && (m_stk.size() != 0 || m_take || sb_vec.size() != 0); i++) begin
         b.reti = 1'b1;
         tick(1);
      end
      tick(3);
      chk("scoreboard drained", 32'(sb_vec.size()), 0);
      chk("final inactive", 32'(b.active), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/irq_vector_ctrl.md
# irq_vector_ctrl

Interrupt controller that sits directly upstream of the PC register in the single-cycle CPU. It synchronises external interrupt lines and latches them as pending requests, then selects the highest-priority unmasked request. It drives a vector address into the PC next-address mux with a one-cycle `take` pulse, saves the return address, and supplies it back to the mux when the CPU executes a return-from-interrupt.

## Interface
- `N_IRQ`, 4: number of interrupt lines. Index 0 has the highest priority.
- `PC_W`, 10: PC width, matching the 10-bit PC adder.
- `VEC_BASE`, 10'h3C0: vector address of IRQ 0.
- `VEC_STRIDE`, 4: address distance between consecutive vectors.
- `NEST_DEPTH`, 4: return-stack depth. Used only with `IRQ_NEST_EN`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `irq_in`  in  N_IRQ  asynchronous request lines, rising-edge sensitive.
- `mask_we`  in  1  mask write strobe.
- `mask_wd`  in  N_IRQ  new mask value (1 = enabled).
- `pc_next`  in  PC_W  address the PC would load absent an interrupt; this is the return address.
- `reti`  in  1  one-cycle pulse while the CPU executes return-from-interrupt.
- `take`  out  1  one-cycle pulse; the PC mux selects `vec_out` on the closing edge.
- `vec_out`  out  PC_W  vector address, valid while `take`=1.
- `ret_addr`  out  PC_W  saved return address; the PC mux selects it when `reti`=1.
- `active`  out  1  an interrupt is being serviced.
- `active_id`  out  $clog2(N_IRQ)  index of the interrupt being serviced.
- `pending_q`  out  N_IRQ  latched requests.
- `mask_q`  out  N_IRQ  current mask.

## Operation
- **Synchronisation:** each `irq_in` bit passes through a 2-FF synchroniser plus a delay FF. A rising edge (sync=1, delayed=0) sets its `pending_q` bit.
- **Priority:** `sel` is the isolated lowest set bit of `pending_q & mask_q`. Its index is `sel_id`.
- **Vector:** `vec_out` = `VEC_BASE + sel_id*VEC_STRIDE`, truncated to PC_W bits. The selection is frozen on entry to TAKE.
- **IDLE:**
  - If `pending_q & mask_q` ≠ 0, go to TAKE.
  - `reti` is ignored.
- **TAKE:** `take`=1 for exactly one cycle. On the closing edge:
  - save `pc_next` and `sel_id`;
  - clear that pending bit;
  - set `active`=1;
  - go to SERVICE.
  - `reti` and mask writes during TAKE are ignored / do not cancel the take.
- **SERVICE:** `ret_addr` shows the saved return address. When `reti`=1, on that edge:
  - restore the previous context;
  - go to IDLE when no context remains, otherwise stay in SERVICE.
- **Simultaneous set and clear** of the same pending bit: set wins, so the bit stays 1.
- **`mask_we`:** loads `mask_q` on the edge. It does not affect bits already pending, which stay latched while masked.
- **Reset, at any time:**
  - state IDLE;
  - `pending_q`=0, `mask_q`=0;
  - `take`=0, `active`=0, `active_id`=0;
  - `ret_addr`=0, `vec_out`=0;
  - synchroniser and stack cleared.
  - An interrupted service is abandoned.

## Timing
- **Latency from `irq_in` to `pending_q`:** `irq_in` goes high before edge E1. `pending_q` is set at E3.
- **Latency from pending to take:** with the bit pending and unmasked at E3, state becomes TAKE at E4 and `take` is high during cycle E4–E5.
- **PC redirect:** PC = `vec_out` and `active`=1 after E5.
- **Return:** `reti` is sampled at edge R. `ret_addr` must be stable throughout the `reti` cycle and is combinational from the stack top. `active` falls at R in non-nested mode.
- **Ordering:** TAKE never overlaps a `reti` acceptance. If `reti` and preemption eligibility coincide in SERVICE, `reti` wins and the take is re-evaluated the next cycle.

## Configuration
- **`IRQ_NEST_EN` defined:**
  - return address and `active_id` are pushed onto a NEST_DEPTH-entry stack;
  - in SERVICE, go to TAKE when `sel_id` < `active_id` and the stack is not full;
  - `reti` pops; `active` falls only when the stack becomes empty;
  - with the stack full, further preemption is blocked and requests stay pending.
- **`IRQ_NEST_EN` undefined:**
  - single return register;
  - no preemption; all requests wait in `pending_q` until IDLE.

## Test plan
- **Reset:** assert `reset` mid-SERVICE → all outputs 0 immediately and state IDLE; the next `reti` is ignored.
- **Single IRQ:** `mask_q`=4'b1111, pulse `irq_in[2]` → `take`=1 one cycle at E4–E5, `vec_out`=10'h3C8, `ret_addr`=`pc_next` sampled at E5; `reti` → `active`=0.
- **Priority:** `irq_in[3]` and `irq_in[1]` rise together → vector 10'h3C4 first. After `reti`, `take` again with 10'h3CC.
- **Masking:** `mask_q`=4'b0001, pulse `irq_in[2]` → no `take`, `pending_q[2]`=1. Then write `mask_q`=4'b0100 → `take` two edges later, vector 10'h3C8.
- **Nesting enabled:** in service of IRQ 3, raise `irq_in[0]` → preempts with vector 10'h3C0. The first `reti` returns to the IRQ 3 handler address and `active` stays 1; the second `reti` drops `active`.
- **Nesting disabled:** same stimulus → no `take` until after the IRQ 3 `reti`.
